su_cmd_ctrl: RTL and testbench

Smart-UART command controller: parses the received UART byte stream, decodes `SU_CMD_WR_WORD` and `SU_CMD_RD_WORD` frames, and executes each as a single 32-bit bus transaction on the lab register bus. For reads it returns an `SU_CMD_RSP` byte followed by the 4 data bytes to the UART transmitter. It sits between the UART RX/TX byte engines and the register bus master port. Bytes that are not part of a command frame are forwarded to the gateway (terminal/core) byte port.

---
 rtl/su_cmd_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_su_cmd_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/su_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// su_cmd_ctrl - Smart-UART command controller
//
// Purpose:
//   Parses the UART receive byte stream for write-word / read-word command
//   frames and executes each one as a single 32-bit transaction on the lab
//   register bus. A read sends back a response header byte followed by the
//   four read-data bytes, MSB first, to the UART transmitter. Any byte seen
//   in IDLE that is not a command opcode is passed through to the gateway
//   byte port.
//
//   Frame formats (all multi-byte fields MSB first):
//     write : SU_CMD_WR_WORD, addr[4], wdata[4]
//     read  : SU_CMD_RD_WORD, addr[4]   -> reply SU_CMD_RSP, rdata[4]
//
// Optional feature:
//   SU_CMD_TIMEOUT_EN - when defined, a partially received frame is abandoned
//   after TIMEOUT_CYCLES clock cycles without a new byte, and err_timeout
//   pulses for one cycle. When undefined there is no counter, err_timeout is
//   constant 0, and the controller waits for frame bytes indefinitely.
//
// Ports:
//   clk          in   1   single clock
//   rst          in   1   synchronous active-high reset
//   rx_byte      in   8   received byte
//   rx_valid     in   1   one-cycle strobe qualifying rx_byte
//   tx_byte      out  8   byte to the UART transmitter
//   tx_valid     out  1   tx_byte valid, held until tx_ready
//   tx_ready     in   1   transmitter accepts the byte when tx_valid is high
//   gw_byte      out  8   pass-through byte to the gateway
//   gw_valid     out  1   one-cycle strobe qualifying gw_byte
//   bus_req      out  1   bus request, held until bus_ack
//   bus_wr       out  1   1 = write, 0 = read
//   bus_addr     out 32   transaction address
//   bus_wdata    out 32   write data
//   bus_rdata    in  32   read data, valid on the bus_ack cycle
//   bus_ack      in   1   one-cycle transaction completion
//   err_drop     out  1   sticky: a byte arrived while busy and was dropped
//   err_timeout  out  1   one-cycle pulse: a frame was aborted by timeout
// ---------------------------------------------------------------------------
module su_cmd_ctrl #(
    parameter logic [7:0]  SU_CMD_WR_WORD = 8'h01,
    parameter logic [7:0]  SU_CMD_RD_WORD = 8'h02,
    parameter logic [7:0]  SU_CMD_RSP     = 8'h03,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  gw_byte,
    output logic        gw_valid,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        err_drop,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RSP_HDR,
        RSP_DATA
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] rsp_data;

`ifdef SU_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // The abort fires on the edge that completes TIMEOUT_CYCLES idle cycles,
    // i.e. when the counter is about to reach TIMEOUT_CYCLES.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    // Single FSM process; every output is a register written here.
    // Address and data are shifted in from the right so that after four
    // bytes the first byte received sits in bits [31:24].
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            rsp_data  <= 32'h0;
            tx_byte   <= 8'h00;
            tx_valid  <= 1'b0;
            gw_byte   <= 8'h00;
            gw_valid  <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            err_drop  <= 1'b0;
`ifdef SU_CMD_TIMEOUT_EN
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            gw_valid <= 1'b0;
`ifdef SU_CMD_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // bus_ack here can only be a stale ack after a reset; ignore it.
                    if (rx_valid) begin
                        if (rx_byte == SU_CMD_WR_WORD) begin
                            bus_wr   <= 1'b1;
                            byte_cnt <= 2'd0;
                            state    <= ADDR;
                        end else if (rx_byte == SU_CMD_RD_WORD) begin
                            bus_wr   <= 1'b0;
                            byte_cnt <= 2'd0;
                            state    <= ADDR;
                        end else begin
                            gw_valid <= 1'b1;
                            gw_byte  <= rx_byte;
                        end
                    end
                end

                ADDR: begin
                    if (rx_valid) begin
                        bus_addr <= {bus_addr[23:0], rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (bus_wr) begin
                                state <= DATA;
                            end else begin
                                bus_req <= 1'b1;
                                state   <= BUS;
                            end
                        end
                    end
                end

                DATA: begin
                    if (rx_valid) begin
                        bus_wdata <= {bus_wdata[23:0], rx_byte};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus_req <= 1'b1;
                            state   <= BUS;
                        end
                    end
                end

                BUS: begin
                    if (rx_valid) begin
                        err_drop <= 1'b1;
                    end
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_wr) begin
                            state <= IDLE;
                        end else begin
                            rsp_data <= bus_rdata;
                            tx_byte  <= SU_CMD_RSP;
                            tx_valid <= 1'b1;
                            state    <= RSP_HDR;
                        end
                    end
                end

                RSP_HDR: begin
                    if (rx_valid) begin
                        err_drop <= 1'b1;
                    end
                    // Load the next byte on the handshake edge so the
                    // transmitter sees back-to-back bytes without a bubble.
                    if (tx_valid && tx_ready) begin
                        tx_byte  <= rsp_data[31:24];
                        rsp_data <= {rsp_data[23:0], 8'h00};
                        byte_cnt <= 2'd0;
                        state    <= RSP_DATA;
                    end
                end

                RSP_DATA: begin
                    if (rx_valid) begin
                        err_drop <= 1'b1;
                    end
                    if (tx_valid && tx_ready) begin
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            byte_cnt <= 2'd0;
                            state    <= IDLE;
                        end else begin
                            tx_byte  <= rsp_data[31:24];
                            rsp_data <= {rsp_data[23:0], 8'h00};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef SU_CMD_TIMEOUT_EN
            // Inter-byte timer, live only while a frame is being collected.
            // The abort path only triggers on cycles without rx_valid, so it
            // never conflicts with the byte-collection updates above.
            if (state == ADDR || state == DATA) begin
                if (rx_valid) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt     <= '0;
                    byte_cnt    <= 2'd0;
                    err_timeout <= 1'b1;
                    state       <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_su_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_su_cmd_ctrl - directed self-checking bench for su_cmd_ctrl
//
// Inputs are driven 1 time unit after each rising edge and outputs are
// checked at the same point (after the registers have settled). A negedge
// monitor keeps running tallies of gateway strobes, bus request rising
// edges, timeout pulses, transmitter handshakes and tx_valid protocol
// violations.
// ---------------------------------------------------------------------------
module tb_su_cmd_ctrl;

`ifdef SU_CMD_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 50;
`else
    localparam int unsigned TB_TIMEOUT = 1000000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  gw_byte;
    logic        gw_valid;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic        err_drop;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    bit   randReady = 1'b0;
    int   gwCount   = 0;
    int   reqRises  = 0;
    int   tmoPulses = 0;
    int   txViol    = 0;
    logic [7:0] txLog[$];
    logic prevReq   = 1'b0;
    logic prevValid = 1'b0;
    logic prevReady = 1'b0;
    logic prevRst   = 1'b0;

    logic [7:0] expRsp[5];

    su_cmd_ctrl #(
        .SU_CMD_WR_WORD (8'h01),
        .SU_CMD_RD_WORD (8'h02),
        .SU_CMD_RSP     (8'h03),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .gw_byte     (gw_byte),
        .gw_valid    (gw_valid),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .err_drop    (err_drop),
        .err_timeout (err_timeout)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    // Transmitter back-pressure: always ready unless the random mode is on.
    always @(posedge clk) begin
        #1;
        tx_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Negedge monitor: inputs are stable here for the coming rising edge,
    // so tx_valid && tx_ready means a handshake is about to happen.
    always @(negedge clk) begin
        if (gw_valid) gwCount++;
        if (err_timeout) tmoPulses++;
        if (bus_req && !prevReq) reqRises++;
        if (prevValid && !prevReady && !tx_valid && !prevRst) txViol++;
        if (tx_valid && tx_ready && !rst) txLog.push_back(tx_byte);
        prevReq   = bus_req;
        prevValid = tx_valid;
        prevReady = tx_ready;
        prevRst   = rst;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one received byte as a single-cycle strobe.
    task automatic applyStimulus(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
    endtask

    // One-cycle bus acknowledge with the given read data.
    task automatic ackBus(input logic [31:0] rdata);
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        step(1);
        bus_ack   = 1'b0;
    endtask

    // Wait (bounded) until n transmitter handshakes have been logged.
    task automatic waitTx(input int n);
        for (int i = 0; i < 300 && txLog.size() < n; i++) step(1);
    endtask

    // Cycle-exact response check with tx_ready held high: header at M+1,
    // one data byte per cycle after that, tx_valid low after the 4th byte.
    task automatic checkResponse(input string tag, input logic [31:0] rdata);
        logic [31:0] r;
        r = rdata;
        checkOutput({tag, " hdr valid"}, 32'(tx_valid), 32'h1);
        checkOutput({tag, " hdr byte"}, 32'(tx_byte), 32'h03);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checkOutput({tag, " data valid"}, 32'(tx_valid), 32'h1);
            checkOutput({tag, " data byte"}, 32'(tx_byte), 32'(r[31:24]));
            r = {r[23:0], 8'h00};
        end
        step(1);
        checkOutput({tag, " valid drop"}, 32'(tx_valid), 32'h0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        step(3);
        checkOutput("rst tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("rst tx_byte", 32'(tx_byte), 32'h0);
        checkOutput("rst gw_valid", 32'(gw_valid), 32'h0);
        checkOutput("rst gw_byte", 32'(gw_byte), 32'h0);
        checkOutput("rst bus_req", 32'(bus_req), 32'h0);
        checkOutput("rst bus_wr", 32'(bus_wr), 32'h0);
        checkOutput("rst bus_addr", bus_addr, 32'h0);
        checkOutput("rst bus_wdata", bus_wdata, 32'h0);
        checkOutput("rst err_drop", 32'(err_drop), 32'h0);
        checkOutput("rst err_timeout", 32'(err_timeout), 32'h0);
        rst = 1'b0;
        step(1);

        // ---------------- write word ----------------
        $display("[TB] write 12345678 <- deadbeef");
        applyStimulus(8'h01);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        applyStimulus(8'hde);
        applyStimulus(8'had);
        applyStimulus(8'hbe);
        checkOutput("wr req before last", 32'(bus_req), 32'h0);
        applyStimulus(8'hef);
        checkOutput("wr req at N+1", 32'(bus_req), 32'h1);
        checkOutput("wr bus_wr", 32'(bus_wr), 32'h1);
        checkOutput("wr bus_addr", bus_addr, 32'h12345678);
        checkOutput("wr bus_wdata", bus_wdata, 32'hdeadbeef);
        step(2);
        checkOutput("wr req held", 32'(bus_req), 32'h1);
        ackBus(32'h0);
        checkOutput("wr req drop", 32'(bus_req), 32'h0);
        checkOutput("wr no tx", 32'(tx_valid), 32'h0);
        step(2);
        checkOutput("wr tx log", 32'(txLog.size()), 32'd0);
        checkOutput("wr gw count", 32'(gwCount), 32'd0);
        checkOutput("wr req rises", 32'(reqRises), 32'd1);

        // ---------------- read word, random tx_ready ----------------
        $display("[TB] read 00000100 with random tx_ready");
        randReady = 1'b1;
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        checkOutput("rd req", 32'(bus_req), 32'h1);
        checkOutput("rd bus_wr", 32'(bus_wr), 32'h0);
        checkOutput("rd bus_addr", bus_addr, 32'h00000100);
        step(3);
        ackBus(32'hcafe0001);
        checkOutput("rd req drop", 32'(bus_req), 32'h0);
        checkOutput("rd hdr valid", 32'(tx_valid), 32'h1);
        checkOutput("rd hdr byte", 32'(tx_byte), 32'h03);
        waitTx(5);
        step(2);
        expRsp = '{8'h03, 8'hca, 8'hfe, 8'h00, 8'h01};
        checkOutput("rd tx count", 32'(txLog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < txLog.size())
                checkOutput("rd tx byte", 32'(txLog[i]), 32'(expRsp[i]));
        end
        checkOutput("rd tx idle", 32'(tx_valid), 32'h0);
        randReady = 1'b0;
        txLog.delete();
        step(1);

        // ---------------- pass-through ----------------
        $display("[TB] pass-through h i LF");
        expRsp = '{8'h68, 8'h69, 8'h0a, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(expRsp[i]);
            checkOutput("gw valid", 32'(gw_valid), 32'h1);
            checkOutput("gw byte", 32'(gw_byte), 32'(expRsp[i]));
        end
        step(1);
        checkOutput("gw strobe end", 32'(gw_valid), 32'h0);
        checkOutput("gw count", 32'(gwCount), 32'd3);
        checkOutput("gw no req", 32'(reqRises), 32'd2);

        // ---------------- opcode value as payload ----------------
        $display("[TB] opcode byte inside address");
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h05);
        checkOutput("pl req", 32'(bus_req), 32'h1);
        checkOutput("pl bus_wr", 32'(bus_wr), 32'h1);
        checkOutput("pl bus_addr", bus_addr, 32'h02000010);
        checkOutput("pl bus_wdata", bus_wdata, 32'h00000005);
        checkOutput("pl gw count", 32'(gwCount), 32'd3);
        ackBus(32'h0);
        step(1);

        // ---------------- busy drop ----------------
        $display("[TB] byte arriving during BUS");
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h20);
        checkOutput("drop req", 32'(bus_req), 32'h1);
        checkOutput("drop before", 32'(err_drop), 32'h0);
        applyStimulus(8'h55);
        checkOutput("drop no gw", 32'(gw_valid), 32'h0);
        checkOutput("drop flag", 32'(err_drop), 32'h1);
        checkOutput("drop req held", 32'(bus_req), 32'h1);
        checkOutput("drop addr", bus_addr, 32'h00000020);
        ackBus(32'h12345678);
        checkOutput("drop req drop", 32'(bus_req), 32'h0);
        checkResponse("drop rsp", 32'h12345678);
        checkOutput("drop sticky", 32'(err_drop), 32'h1);
        checkOutput("drop gw count", 32'(gwCount), 32'd3);

        // ---------------- reset mid-frame ----------------
        $display("[TB] reset mid-frame");
        applyStimulus(8'h01);
        applyStimulus(8'haa);
        applyStimulus(8'hbb);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("mid rst req", 32'(bus_req), 32'h0);
        checkOutput("mid rst drop", 32'(err_drop), 32'h0);
        checkOutput("mid rst addr", bus_addr, 32'h0);
        checkOutput("mid rst wr", 32'(bus_wr), 32'h0);
        ackBus(32'hffffffff);
        step(1);
        checkOutput("late ack req", 32'(bus_req), 32'h0);
        checkOutput("late ack tx", 32'(tx_valid), 32'h0);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h04);
        checkOutput("post rst req", 32'(bus_req), 32'h1);
        checkOutput("post rst wr", 32'(bus_wr), 32'h0);
        checkOutput("post rst addr", bus_addr, 32'h00000004);
        // Ack lands in the very first cycle bus_req is high.
        ackBus(32'ha1b2c3d4);
        checkOutput("fast ack req drop", 32'(bus_req), 32'h0);
        checkResponse("fast ack rsp", 32'ha1b2c3d4);
        checkOutput("req rises", 32'(reqRises), 32'd5);

        // ---------------- reset during response ----------------
        $display("[TB] reset during response");
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h08);
        ackBus(32'h11111111);
        checkOutput("rsp rst pre", 32'(tx_valid), 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("rsp rst valid", 32'(tx_valid), 32'h0);
        checkOutput("rsp rst byte", 32'(tx_byte), 32'h0);
        step(2);
        checkOutput("rsp rst stays idle", 32'(tx_valid), 32'h0);

        // ---------------- inter-byte timeout ----------------
`ifdef SU_CMD_TIMEOUT_EN
        $display("[TB] timeout enabled, 50 cycles");
        applyStimulus(8'h01);
        applyStimulus(8'h11);
        step(40);
        checkOutput("tmo not early", 32'(tmoPulses), 32'd0);
        step(20);
        checkOutput("tmo pulse", 32'(tmoPulses), 32'd1);
        checkOutput("tmo no req", 32'(reqRises), 32'd6);
        checkOutput("tmo pulse ended", 32'(err_timeout), 32'h0);
        applyStimulus(8'h41);
        checkOutput("tmo gw valid", 32'(gw_valid), 32'h1);
        checkOutput("tmo gw byte", 32'(gw_byte), 32'h41);
`else
        $display("[TB] timeout disabled, frame waits");
        applyStimulus(8'h01);
        applyStimulus(8'h11);
        step(60);
        checkOutput("no tmo pulse", 32'(tmoPulses), 32'd0);
        checkOutput("no tmo req", 32'(bus_req), 32'h0);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h07);
        checkOutput("slow req", 32'(bus_req), 32'h1);
        checkOutput("slow addr", bus_addr, 32'h11223344);
        checkOutput("slow wdata", bus_wdata, 32'h00000007);
        checkOutput("slow gw count", 32'(gwCount), 32'd3);
        ackBus(32'h0);
        checkOutput("slow req drop", 32'(bus_req), 32'h0);
`endif

        step(2);
        checkOutput("tx_valid protocol", 32'(txViol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
